// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin arbiter from N user masters onto the single
// command port of the DRAM controller wrapper, with in-order read steering.
//
// Ports:
//   clock, reset                    - controller clock, async active-high reset
//   p_ren/p_wen/p_addr/p_wdata/
//   p_wmask                         - per-port requests, flattened by port index
//   p_ack                           - one-hot, combinational command-taken strobe
//   p_rdata/p_rdata_valid           - broadcast read data, one-hot owner strobe
//   dram_ren/wen/addr/wdata/wmask   - registered command slot toward controller
//   dram_busy, dram_init_calib_complete, dram_rdata, dram_rdata_valid
//                                   - controller status and read return
//   err                             - sticky protocol-error flag
module dram_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int RD_DEPTH   = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             p_ren,
    input  logic [NUM_PORTS-1:0]             p_wen,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_wdata,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  p_wmask,
    output logic [NUM_PORTS-1:0]             p_ack,
    output logic [DATA_WIDTH-1:0]            p_rdata,
    output logic [NUM_PORTS-1:0]             p_rdata_valid,
    output logic                             dram_ren,
    output logic                             dram_wen,
    output logic [ADDR_WIDTH-1:0]            dram_addr,
    output logic [DATA_WIDTH-1:0]            dram_wdata,
    output logic [MASK_WIDTH-1:0]            dram_wmask,
    input  logic                             dram_busy,
    input  logic                             dram_init_calib_complete,
    input  logic [DATA_WIDTH-1:0]            dram_rdata,
    input  logic                             dram_rdata_valid,
    output logic                             err
);

    localparam int IDXW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTRW = $clog2(RD_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(RD_DEPTH);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_PORTS - 1);

    // Command slot
    logic                  ren_q, ren_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;

    // Arbitration state
    logic [IDXW-1:0] last_q, last_d;
    logic            err_q, err_d;

    // Read tag FIFO
    logic [IDXW-1:0] tag_q [RD_DEPTH];
    logic [PTRW-1:0] wptr_q, rptr_q;
    logic [CNTW-1:0] cnt_q;

    logic                  occupied;
    logic                  accept;
    logic                  can_load;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push;
    logic                  room;
    logic [NUM_PORTS-1:0]  eligible;
    logic                  found;
    logic [IDXW-1:0]       win_idx;
    logic                  load;
    logic                  sel_ren;
    logic                  sel_wen;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [MASK_WIDTH-1:0] sel_wmask;
    logic [IDXW-1:0]       head;
    int                    idx;

    // Slot and FIFO status
    always_comb begin
        occupied   = ren_q | wen_q;
        accept     = occupied & ~dram_busy;
        // Reset is folded in so no ack leaks out while reset is held.
        can_load   = dram_init_calib_complete & ~reset & (~occupied | accept);
        fifo_empty = (cnt_q == '0);
        pop        = dram_rdata_valid & ~fifo_empty;
        // A pop in this cycle frees the entry a new read would need.
        room       = (cnt_q != DEPTH_C) | pop;
        // A read+write pair counts as a write, so it never waits on room.
        eligible   = p_wen | (p_ren & {NUM_PORTS{room}});
    end

    // Round-robin search starting one past the last winner
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_q) + k) % NUM_PORTS;
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win_idx = IDXW'(idx);
            end
        end
        load = found & can_load;
    end

    // Winner operand mux
    always_comb begin
        sel_ren   = p_ren[win_idx];
        sel_wen   = p_wen[win_idx];
        sel_addr  = p_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = p_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
        sel_wmask = p_wmask[win_idx*MASK_WIDTH +: MASK_WIDTH];
        push      = load & sel_ren & ~sel_wen;
    end

    // Slot next state
    always_comb begin
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        last_d  = last_q;
        if (load) begin
            ren_d   = sel_ren & ~sel_wen;
            wen_d   = sel_wen;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            wmask_d = sel_wmask;
            last_d  = win_idx;
        end else if (accept) begin
            ren_d = 1'b0;
            wen_d = 1'b0;
        end
    end

    always_comb begin
        err_d = err_q
              | (dram_rdata_valid & fifo_empty)
              | (|(p_ren & p_wen));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            last_q  <= LAST_RST;
            err_q   <= 1'b0;
        end else begin
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Tag FIFO: a read is tracked from the moment it loads into the slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                tag_q[wptr_q] <= win_idx;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        head          = tag_q[rptr_q];
        p_ack         = load ? (NUM_PORTS'(1) << win_idx) : '0;
        p_rdata_valid = pop ? (NUM_PORTS'(1) << head) : '0;
        p_rdata       = dram_rdata;
        dram_ren      = ren_q;
        dram_wen      = wen_q;
        dram_addr     = addr_q;
        dram_wdata    = wdata_q;
        dram_wmask    = wmask_q;
        err           = err_q;
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed and random checks of dram_port_arbiter
// against a queue-based reference model, with three ports.
module tb_dram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 27;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int D  = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    p_ren;
    logic [N-1:0]    p_wen;
    logic [N*AW-1:0] p_addr;
    logic [N*DW-1:0] p_wdata;
    logic [N*MW-1:0] p_wmask;
    logic [N-1:0]    p_ack;
    logic [DW-1:0]   p_rdata;
    logic [N-1:0]    p_rdata_valid;
    logic            dram_ren;
    logic            dram_wen;
    logic [AW-1:0]   dram_addr;
    logic [DW-1:0]   dram_wdata;
    logic [MW-1:0]   dram_wmask;
    logic            dram_busy;
    logic            calib;
    logic [DW-1:0]   dram_rdata;
    logic            dram_rdata_valid;
    logic            err;

    dram_port_arbiter #(
        .NUM_PORTS (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MASK_WIDTH(MW),
        .RD_DEPTH  (D)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .p_ren                   (p_ren),
        .p_wen                   (p_wen),
        .p_addr                  (p_addr),
        .p_wdata                 (p_wdata),
        .p_wmask                 (p_wmask),
        .p_ack                   (p_ack),
        .p_rdata                 (p_rdata),
        .p_rdata_valid           (p_rdata_valid),
        .dram_ren                (dram_ren),
        .dram_wen                (dram_wen),
        .dram_addr               (dram_addr),
        .dram_wdata              (dram_wdata),
        .dram_wmask              (dram_wmask),
        .dram_busy               (dram_busy),
        .dram_init_calib_complete(calib),
        .dram_rdata              (dram_rdata),
        .dram_rdata_valid        (dram_rdata_valid),
        .err                     (err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_ren;
    bit            m_wen;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    int            m_last;
    int            m_q[$];
    bit            m_err;
    bit            m_pop;
    bit            m_acc;
    int            win;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int i, input bit r, input bit w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m);
        p_ren[i] = r;
        p_wen[i] = w;
        p_addr[i*AW +: AW] = a;
        p_wdata[i*DW +: DW] = d;
        p_wmask[i*MW +: MW] = m;
    endtask

    task automatic drop(input int i);
        p_ren[i] = 1'b0;
        p_wen[i] = 1'b0;
    endtask

    // Evaluate the model's combinational view and compare every output.
    task automatic settle();
        bit occ;
        bit can;
        bit room;
        int i;
        logic [N-1:0] exp_ack;
        logic [N-1:0] exp_rv;
        #1;
        occ   = m_ren || m_wen;
        m_acc = occ && !dram_busy;
        can   = calib && (!occ || m_acc);
        m_pop = dram_rdata_valid && (m_q.size() > 0);
        room  = (m_q.size() < D) || m_pop;
        win   = -1;
        if (can) begin
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (win < 0 && (p_wen[i] || (p_ren[i] && room))) win = i;
            end
        end
        exp_ack = (win >= 0) ? N'(1 << win) : '0;
        exp_rv  = m_pop ? N'(1 << m_q[0]) : '0;
        chk("p_ack", p_ack, exp_ack);
        chk("p_rdata_valid", p_rdata_valid, exp_rv);
        chk("p_rdata", p_rdata, dram_rdata);
        chk("dram_ren", dram_ren, m_ren);
        chk("dram_wen", dram_wen, m_wen);
        chk("dram_addr", dram_addr, m_addr);
        chk("dram_wdata", dram_wdata, m_wdata);
        chk("dram_wmask", dram_wmask, m_wmask);
        chk("err", err, m_err);
    endtask

    task automatic tick();
        @(posedge clock);
        if (dram_rdata_valid && m_q.size() == 0) m_err = 1'b1;
        if ((p_ren & p_wen) != '0) m_err = 1'b1;
        if (m_pop) void'(m_q.pop_front());
        if (win >= 0) begin
            m_wen   = p_wen[win];
            m_ren   = p_ren[win] && !p_wen[win];
            m_addr  = p_addr[win*AW +: AW];
            m_wdata = p_wdata[win*DW +: DW];
            m_wmask = p_wmask[win*MW +: MW];
            if (m_ren) m_q.push_back(win);
            m_last = win;
        end else if (m_acc) begin
            m_ren = 1'b0;
            m_wen = 1'b0;
        end
        @(negedge clock);
    endtask

    // Assert reset, check outputs clear at once, hold across one edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_dram_ren", dram_ren, 1'b0);
        chk("rst_dram_wen", dram_wen, 1'b0);
        chk("rst_dram_addr", dram_addr, '0);
        chk("rst_dram_wdata", dram_wdata, '0);
        chk("rst_dram_wmask", dram_wmask, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_p_ack", p_ack, '0);
        chk("rst_p_rdata_valid", p_rdata_valid, '0);
        m_ren   = 1'b0;
        m_wen   = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = '0;
        m_last  = N - 1;
        m_err   = 1'b0;
        m_q.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [N-1:0] rr_seq [4];
    logic [DW-1:0] rd_beat [3];
    bit pend [N];

    initial begin
        reset = 1'b1;
        p_ren = '0;
        p_wen = '0;
        p_addr = '0;
        p_wdata = '0;
        p_wmask = '0;
        dram_busy = 1'b0;
        calib = 1'b1;
        dram_rdata = '0;
        dram_rdata_valid = 1'b0;
        do_reset();

        // Single read and its return
        req(0, 1, 0, 27'h1234, '0, '0);
        settle();
        chk("single_ack", p_ack, 3'b001);
        tick();
        drop(0);
        settle();
        chk("single_ren", dram_ren, 1'b1);
        chk("single_addr", dram_addr, 27'h1234);
        tick();
        dram_rdata_valid = 1'b1;
        dram_rdata = {16{8'hA5}};
        settle();
        chk("single_rv", p_rdata_valid, 3'b001);
        chk("single_rdata", p_rdata, {16{8'hA5}});
        tick();
        dram_rdata_valid = 1'b0;

        // Round-robin with all ports writing every cycle
        do_reset();
        rr_seq[0] = 3'b001;
        rr_seq[1] = 3'b010;
        rr_seq[2] = 3'b100;
        rr_seq[3] = 3'b001;
        for (int i = 0; i < N; i++)
            req(i, 0, 1, AW'(32'hB0 + i), DW'(i + 1), MW'(i));
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("rr_ack", p_ack, rr_seq[c]);
            if (c > 0) chk("rr_wen", dram_wen, 1'b1);
            tick();
        end
        for (int i = 0; i < N; i++) drop(i);
        settle();
        tick();

        // Backpressure holds the slot and blocks acks
        do_reset();
        req(0, 0, 1, 27'hC0, {4{32'hDEADBEEF}}, 16'h00F0);
        settle();
        chk("bp_first_ack", p_ack, 3'b001);
        tick();
        drop(0);
        dram_busy = 1'b1;
        req(1, 0, 1, 27'hC1, '1, '0);
        req(2, 0, 1, 27'hC2, '0, '1);
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_ack", p_ack, 3'b000);
            chk("bp_addr", dram_addr, 27'hC0);
            chk("bp_wmask", dram_wmask, 16'h00F0);
            tick();
        end
        dram_busy = 1'b0;
        settle();
        chk("bp_release_ack", p_ack, 3'b010);
        tick();
        drop(1);
        drop(2);
        settle();
        tick();

        // Tag FIFO full: fifth read stalls, a write still passes
        do_reset();
        for (int r = 0; r < 4; r++) begin
            req(0, 1, 0, AW'(32'hD0 + r), '0, '0);
            settle();
            chk("full_rd_ack", p_ack, 3'b001);
            tick();
        end
        req(0, 1, 0, 27'hD4, '0, '0);
        req(1, 0, 1, 27'hE0, '0, '0);
        settle();
        chk("full_wr_ack", p_ack, 3'b010);
        tick();
        drop(1);
        settle();
        chk("full_stall", p_ack, 3'b000);
        tick();
        dram_rdata_valid = 1'b1;
        dram_rdata = {4{32'h5A5A0001}};
        settle();
        chk("full_pop_rv", p_rdata_valid, 3'b001);
        chk("full_pop_ack", p_ack, 3'b001);
        tick();
        drop(0);
        for (int r = 0; r < 4; r++) begin
            settle();
            chk("full_drain_rv", p_rdata_valid, 3'b001);
            tick();
        end
        dram_rdata_valid = 1'b0;

        // Read with write on one port counts as a write and flags err
        do_reset();
        req(2, 1, 1, 27'h77, '1, '0);
        settle();
        chk("dual_ack", p_ack, 3'b100);
        tick();
        drop(2);
        settle();
        chk("dual_wen", dram_wen, 1'b1);
        chk("dual_ren", dram_ren, 1'b0);
        chk("dual_err", err, 1'b1);
        tick();

        // Returns steered in request order; spurious beat sets err
        do_reset();
        req(1, 1, 0, 27'h100, '0, '0);
        settle();
        tick();
        drop(1);
        req(0, 1, 0, 27'h200, '0, '0);
        settle();
        tick();
        drop(0);
        req(1, 1, 0, 27'h300, '0, '0);
        settle();
        tick();
        drop(1);
        rd_beat[0] = {4{32'h11111111}};
        rd_beat[1] = {4{32'h22222222}};
        rd_beat[2] = {4{32'h33333333}};
        rr_seq[0] = 3'b010;
        rr_seq[1] = 3'b001;
        rr_seq[2] = 3'b010;
        dram_rdata_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            dram_rdata = rd_beat[c];
            settle();
            chk("ooo_rv", p_rdata_valid, rr_seq[c]);
            chk("ooo_rdata", p_rdata, rd_beat[c]);
            tick();
        end
        settle();
        chk("spurious_rv", p_rdata_valid, 3'b000);
        tick();
        dram_rdata_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("spurious_err", err, 1'b1);
            tick();
        end

        // Reset with two reads outstanding and the slot occupied
        do_reset();
        req(0, 1, 0, 27'h10, '0, '0);
        settle();
        tick();
        drop(0);
        req(1, 1, 0, 27'h11, '0, '0);
        settle();
        tick();
        drop(1);
        req(2, 0, 1, 27'h12, '1, '1);
        settle();
        tick();
        drop(2);
        dram_busy = 1'b1;
        for (int i = 0; i < N; i++) req(i, 0, 1, AW'(32'h20 + i), '0, '0);
        settle();
        chk("mid_wen", dram_wen, 1'b1);
        do_reset();
        dram_busy = 1'b0;
        settle();
        chk("post_rst_ack", p_ack, 3'b001);
        tick();
        for (int i = 0; i < N; i++) drop(i);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    if ($urandom % 40 == 0)
                        req(i, 1, 1, AW'($urandom), {4{$urandom}}, MW'($urandom));
                    else if ($urandom % 2 == 0)
                        req(i, 1, 0, AW'($urandom), {4{$urandom}}, MW'($urandom));
                    else
                        req(i, 0, 1, AW'($urandom), {4{$urandom}}, MW'($urandom));
                end
            end
            calib = ($urandom % 10) != 0;
            dram_busy = ($urandom % 3) == 0;
            if (m_q.size() > 0) dram_rdata_valid = ($urandom % 2) == 0;
            else dram_rdata_valid = ($urandom % 60) == 0;
            dram_rdata = {$urandom, $urandom, $urandom, $urandom};
            settle();
            tick();
            if (win >= 0) begin
                drop(win);
                pend[win] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
